lc3_ctrl_fsm: RTL
=================

LC3_CTRL_FSM -- requirements
Module: lc3_ctrl_fsm

Interface
REQ-001 SHALL have port Clk, input, 1: the only clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port Run, input, 1: starts execution from HALTED.
REQ-004 SHALL have port Continue, input, 1: resumes execution from PAUSE.
REQ-005 SHALL have port IR, input, 16: instruction register contents.
REQ-006 SHALL have port BEN, input, 1: branch-enable flag.
REQ-007 SHALL have port Mem_R, input, 1: memory ready, one-cycle pulse when an access completes.
REQ-008 SHALL have port gate, output, 4: one-hot bus gate, ordered {GateMDR, GateMARMUX, GatePC, GateALU} (bit3..bit0).
REQ-009 SHALL have port ld, output, 7: register loads, ordered {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC}.
REQ-010 SHALL have ports PCMUX, ADDR2MUX and ALUK, output, 2 each: datapath selects.
REQ-011 SHALL have ports DRMUX, SR1MUX, SR2MUX, ADDR1MUX and MIO_EN, output, 1 each: datapath selects.
REQ-012 SHALL have ports Mem_OE and Mem_WE, output, 1 each: memory strobes, active-low.
REQ-013 SHALL have parameter MEM_TIMEOUT, default 15: number of wait cycles in a memory state before abort.

Function
REQ-014 SHALL be a Moore FSM: every output is a function of the state register only.
REQ-015 SHALL have these states: HALTED, F1, F2, F3, DEC, ADD, AND, NOT, BR0, BR1, JMP, LD0, LD1, LD2, ST0, ST1, ST2, PAUSE0, PAUSE1, FAULT.
REQ-016 SHALL decode opcode = IR[15:12] in DEC as follows: 0001→ADD, 0101→AND, 1001→NOT, 0000→BR0, 1100→JMP, 0010→LD0, 0011→ST0, 1101→PAUSE0; every other opcode SHALL go to F1.
REQ-017 SHALL drive in F1 (1 cycle): gate=0010, LD_MAR=1, PCMUX=00 (PC+1), LD_PC=1; next state F2.
REQ-018 SHALL drive in F2: Mem_OE=0, MIO_EN=1, LD_MDR=1; it SHALL stay in F2 until Mem_R=1, then go to F3.
REQ-019 SHALL drive in F3 (1 cycle): gate=1000, LD_IR=1; next state DEC; LD_BEN=1 in DEC.
REQ-020 SHALL, in ADD and AND, assert gate=0001, LD_REG=1 and LD_CC=1 with ALUK=00 and 01 respectively, and SR2MUX=IR[5]; NOT SHALL use ALUK=10 with the same loads; all three SHALL return to F1.
REQ-021 SHALL, in BR0, go to BR1 if BEN=1, else to F1; BR1 SHALL assert LD_PC=1, PCMUX=10, ADDR1MUX=0 and ADDR2MUX=10, then go to F1.
REQ-022 SHALL, in JMP, assert LD_PC=1, PCMUX=01 and SR1MUX=1, then go to F1.
REQ-023 SHALL, in LD0 and ST0, assert gate=0100, LD_MAR=1 and ADDR2MUX=10.
REQ-024 SHALL, in LD1, wait on Mem_R like F2; LD2 SHALL assert gate=1000, LD_REG=1 and LD_CC=1.
REQ-025 SHALL, in ST1, assert gate=0001, LD_MDR=1 and MIO_EN=0; ST2 SHALL hold Mem_WE=0 until Mem_R=1.
REQ-026 SHALL have PAUSE0 hold until Continue=1, then go to PAUSE1; PAUSE1 SHALL hold until Continue=0, then go to F1.
REQ-027 SHALL have HALTED hold until Run=1, then go to F1.
REQ-028 SHALL drive gate only with values 0000 or a single set bit; two set bits SHALL never occur.
REQ-029 SHALL keep a 4-bit wait counter that clears on entry to F2, LD1 or ST2, increments each cycle spent there, and forces state FAULT when it reaches MEM_TIMEOUT without Mem_R.
REQ-030 SHALL, in FAULT, drive all outputs inactive and remain there until reset.
REQ-031 SHALL give priority to Mem_R when Mem_R=1 arrives on the same cycle the counter reaches MEM_TIMEOUT.
REQ-032 SHALL ignore Run except in HALTED, and Continue except in PAUSE0 and PAUSE1.

Reset
REQ-033 SHALL, on Reset=0 and regardless of Clk, go to HALTED, clear the counter, set gate=0000, ld=0 and all selects to 0, and set Mem_OE=Mem_WE=1.
REQ-034 SHALL, on reset during a memory wait, abort the access and raise the strobes immediately.

Structure
REQ-035 SHALL place the state enum, opcode constants and the ALUK/PCMUX/ADDR2MUX encodings in the shared package lc3_pkg.
REQ-036 SHALL be a single module with no sub-modules; gate SHALL connect directly to the bus multiplexer gate inputs.

Verification
REQ-037 Bench SHALL check fetch: Run pulse, PC=0x3000, Mem_R asserted 3 cycles after entering F2 → F1,F2,F2,F2,F3,DEC; LD_IR in F3.
REQ-038 Bench SHALL check ADD: IR=0x1283 → DEC→ADD→F1, gate=0001, ALUK=00, LD_REG=LD_CC=1 for exactly 1 cycle.
REQ-039 Bench SHALL check branches: IR=0x0E05 with BEN=0 → BR0→F1; with BEN=1 → BR0→BR1→F1, LD_PC=1, PCMUX=10.
REQ-040 Bench SHALL check ST: IR=0x3201, Mem_R after 2 cycles → Mem_WE low for 2 cycles, then F1.
REQ-041 Bench SHALL check timeout: Mem_R held low in F2 → FAULT after 15 cycles, outputs inactive until Reset=0.
REQ-042 Bench SHALL check reset mid-LD1 (Mem_OE=0) → Mem_OE=1 and state HALTED asynchronously, then gate is one-hot or zero on every cycle afterwards.

Source files
------------

// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_pkg
//  Description : Shared state, opcode and datapath-select encodings for the
//                LC-3 control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

    typedef enum logic [4:0] {
        ST_HALTED = 5'd0,
        ST_F1     = 5'd1,
        ST_F2     = 5'd2,
        ST_F3     = 5'd3,
        ST_DEC    = 5'd4,
        ST_ADD    = 5'd5,
        ST_AND    = 5'd6,
        ST_NOT    = 5'd7,
        ST_BR0    = 5'd8,
        ST_BR1    = 5'd9,
        ST_JMP    = 5'd10,
        ST_LD0    = 5'd11,
        ST_LD1    = 5'd12,
        ST_LD2    = 5'd13,
        ST_ST0    = 5'd14,
        ST_ST1    = 5'd15,
        ST_ST2    = 5'd16,
        ST_PAUSE0 = 5'd17,
        ST_PAUSE1 = 5'd18,
        ST_FAULT  = 5'd19
    } state_t;

    localparam logic [3:0] c_op_br    = 4'b0000;
    localparam logic [3:0] c_op_add   = 4'b0001;
    localparam logic [3:0] c_op_ld    = 4'b0010;
    localparam logic [3:0] c_op_st    = 4'b0011;
    localparam logic [3:0] c_op_and   = 4'b0101;
    localparam logic [3:0] c_op_not   = 4'b1001;
    localparam logic [3:0] c_op_jmp   = 4'b1100;
    localparam logic [3:0] c_op_pause = 4'b1101;

    localparam logic [1:0] c_aluk_add = 2'b00;
    localparam logic [1:0] c_aluk_and = 2'b01;
    localparam logic [1:0] c_aluk_not = 2'b10;

    localparam logic [1:0] c_pcmux_inc  = 2'b00;
    localparam logic [1:0] c_pcmux_reg  = 2'b01;
    localparam logic [1:0] c_pcmux_addr = 2'b10;

    localparam logic [1:0] c_addr2_zero = 2'b00;
    localparam logic [1:0] c_addr2_off9 = 2'b10;

    // One-hot bus gate codes: {GateMDR, GateMARMUX, GatePC, GateALU}
    localparam logic [3:0] c_gate_none   = 4'b0000;
    localparam logic [3:0] c_gate_alu    = 4'b0001;
    localparam logic [3:0] c_gate_pc     = 4'b0010;
    localparam logic [3:0] c_gate_marmux = 4'b0100;
    localparam logic [3:0] c_gate_mdr    = 4'b1000;

    // Bit positions inside ld = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC}
    localparam int c_ld_pc  = 0;
    localparam int c_ld_reg = 1;
    localparam int c_ld_cc  = 2;
    localparam int c_ld_ben = 3;
    localparam int c_ld_ir  = 4;
    localparam int c_ld_mdr = 5;
    localparam int c_ld_mar = 6;

    function automatic logic is_mem_wait(input state_t s);
        return (s == ST_F2) || (s == ST_LD1) || (s == ST_ST2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_ctrl_fsm
//  Description : Moore control FSM for a simplified LC-3 datapath with a
//                bounded memory-wait timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_ctrl_fsm
    import lc3_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    input  logic        Mem_R,
    output logic [3:0]  gate,
    output logic [6:0]  ld,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       r_ir5;
    logic       w_timeout;
    logic       w_ir_unused;

    assign w_ir_unused = ^{IR[11:6], IR[4:0]};

    // Limit is hit on the cycle whose increment would reach MEM_TIMEOUT
    assign w_timeout  = (({1'b0, r_cnt} + 5'd1) == 5'(MEM_TIMEOUT));
    assign w_cnt_next = (is_mem_wait(r_state) && (w_state_next == r_state)) ? (r_cnt + 4'd1) : 4'd0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_HALTED;
            r_cnt   <= 4'd0;
            r_ir5   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // Immediate-mode bit is registered so SR2MUX stays a pure state output
            if (r_state == ST_DEC) begin
                r_ir5 <= IR[5];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        gate         = c_gate_none;
        ld           = 7'd0;
        PCMUX        = c_pcmux_inc;
        ADDR2MUX     = c_addr2_zero;
        ALUK         = c_aluk_add;
        DRMUX        = 1'b0;
        SR1MUX       = 1'b0;
        SR2MUX       = 1'b0;
        ADDR1MUX     = 1'b0;
        MIO_EN       = 1'b0;
        Mem_OE       = 1'b1;
        Mem_WE       = 1'b1;

        case (r_state)
            ST_HALTED: begin
                if (Run) w_state_next = ST_F1;
            end
            ST_F1: begin
                gate          = c_gate_pc;
                ld[c_ld_mar]  = 1'b1;
                ld[c_ld_pc]   = 1'b1;
                PCMUX         = c_pcmux_inc;
                w_state_next  = ST_F2;
            end
            ST_F2: begin
                Mem_OE        = 1'b0;
                MIO_EN        = 1'b1;
                ld[c_ld_mdr]  = 1'b1;
                if (Mem_R)          w_state_next = ST_F3;
                else if (w_timeout) w_state_next = ST_FAULT;
            end
            ST_F3: begin
                gate          = c_gate_mdr;
                ld[c_ld_ir]   = 1'b1;
                w_state_next  = ST_DEC;
            end
            ST_DEC: begin
                ld[c_ld_ben]  = 1'b1;
                case (IR[15:12])
                    c_op_add:   w_state_next = ST_ADD;
                    c_op_and:   w_state_next = ST_AND;
                    c_op_not:   w_state_next = ST_NOT;
                    c_op_br:    w_state_next = ST_BR0;
                    c_op_jmp:   w_state_next = ST_JMP;
                    c_op_ld:    w_state_next = ST_LD0;
                    c_op_st:    w_state_next = ST_ST0;
                    c_op_pause: w_state_next = ST_PAUSE0;
                    default:    w_state_next = ST_F1;
                endcase
            end
            ST_ADD, ST_AND, ST_NOT: begin
                gate          = c_gate_alu;
                ld[c_ld_reg]  = 1'b1;
                ld[c_ld_cc]   = 1'b1;
                ALUK          = (r_state == ST_ADD) ? c_aluk_add :
                                (r_state == ST_AND) ? c_aluk_and : c_aluk_not;
                SR2MUX        = (r_state != ST_NOT) && r_ir5;
                w_state_next  = ST_F1;
            end
            ST_BR0: begin
                w_state_next  = BEN ? ST_BR1 : ST_F1;
            end
            ST_BR1: begin
                ld[c_ld_pc]   = 1'b1;
                PCMUX         = c_pcmux_addr;
                ADDR1MUX      = 1'b0;
                ADDR2MUX      = c_addr2_off9;
                w_state_next  = ST_F1;
            end
            ST_JMP: begin
                ld[c_ld_pc]   = 1'b1;
                PCMUX         = c_pcmux_reg;
                SR1MUX        = 1'b1;
                w_state_next  = ST_F1;
            end
            ST_LD0, ST_ST0: begin
                gate          = c_gate_marmux;
                ld[c_ld_mar]  = 1'b1;
                ADDR2MUX      = c_addr2_off9;
                w_state_next  = (r_state == ST_LD0) ? ST_LD1 : ST_ST1;
            end
            ST_LD1: begin
                Mem_OE        = 1'b0;
                MIO_EN        = 1'b1;
                ld[c_ld_mdr]  = 1'b1;
                if (Mem_R)          w_state_next = ST_LD2;
                else if (w_timeout) w_state_next = ST_FAULT;
            end
            ST_LD2: begin
                gate          = c_gate_mdr;
                ld[c_ld_reg]  = 1'b1;
                ld[c_ld_cc]   = 1'b1;
                w_state_next  = ST_F1;
            end
            ST_ST1: begin
                gate          = c_gate_alu;
                ld[c_ld_mdr]  = 1'b1;
                MIO_EN        = 1'b0;
                w_state_next  = ST_ST2;
            end
            ST_ST2: begin
                Mem_WE        = 1'b0;
                if (Mem_R)          w_state_next = ST_F1;
                else if (w_timeout) w_state_next = ST_FAULT;
            end
            ST_PAUSE0: begin
                if (Continue) w_state_next = ST_PAUSE1;
            end
            ST_PAUSE1: begin
                if (!Continue) w_state_next = ST_F1;
            end
            ST_FAULT: begin
                w_state_next  = ST_FAULT;
            end
            default: begin
                w_state_next  = ST_FAULT;
            end
        endcase
    end

endmodule
`default_nettype wire
